// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// State list grows a PARITY state when SERIAL_FRAME_TX_PARITY_EN is defined.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts DIV cycles, pulses bit_end on the last one.
// Latency: bit_end is combinational from the count; no backpressure, clear holds it at zero.
// Backpressure: none.
module serial_bit_timer
    import serial_frame_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        bit_end   = !clear && (div_cnt_q == LAST);
        div_cnt_d = div_cnt_q;
        if (clear || (div_cnt_q == LAST)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: start, WIDTH data bits LSB first, [even parity], stop.
// Latency: start bit on o_ser the cycle after accept; o_done pulses in the first idle cycle.
// Backpressure: o_ready low for the whole frame; parity via SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_ser,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             ser_q, ser_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The timer free-runs through the whole frame so bit periods stay contiguous.
    serial_bit_timer #(.DIV(DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == TX_IDLE),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            TX_IDLE: begin
                if (i_valid && ready_q) begin
                    state_d   = TX_START;
                    shift_d   = i_data;
                    bit_cnt_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d  = ^i_data;
`endif
                end
            end
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            TX_PARITY: if (bit_end) state_d = TX_STOP;
`endif
            TX_STOP: if (bit_end) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase

        // Outputs are computed from the next state so they are registered yet aligned with it.
        ser_d = LINE_IDLE;
        case (state_d)
            TX_START:  ser_d = START_LEVEL;
            TX_DATA:   ser_d = shift_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            TX_PARITY: ser_d = parity_d;
`endif
            TX_STOP:   ser_d = STOP_LEVEL;
            default:   ser_d = LINE_IDLE;
        endcase
        busy_d  = (state_d != TX_IDLE);
        ready_d = (state_d == TX_IDLE);
        done_d  = (state_q == TX_STOP) && (state_d == TX_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ser_q     <= LINE_IDLE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_ser   = ser_q;
    assign o_busy  = busy_q;
    assign o_ready = ready_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (WIDTH=4/DIV=2 and WIDTH=1/DIV=1) checked per cycle
// against a frame model built from bit positions; honours SERIAL_FRAME_TX_PARITY_EN.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int WA = 4;
    localparam int DA = 2;
    localparam int WB = 1;
    localparam int DB = 1;
    localparam int LA = DA * (WA + 2 + PB);
    localparam int LB = DB * (WB + 2 + PB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [WA-1:0] a_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready, a_ser, a_busy, a_done;
    logic [WB-1:0] b_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready, b_ser, b_busy, b_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(WA), .DIV(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready), .o_ser(a_ser), .o_busy(a_busy), .o_done(a_done)
    );

    serial_frame_tx #(.WIDTH(WB), .DIV(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .o_ser(b_ser), .o_busy(b_busy), .o_done(b_done)
    );

    // Line level k cycles into a frame, derived from which bit slot k falls in.
    function automatic logic exp_ser(input int d, input int w, input int div, input int k);
        logic [31:0] dv;
        int          slot;
        int          ones;
        dv   = d;
        slot = k / div;
        ones = 0;
        for (int i = 0; i < w; i++) ones += dv[i];
        if (slot == 0) return 1'b0;
        if (slot <= w) return dv[slot-1];
        if (PB == 1 && slot == w + 1) return (ones % 2) == 1;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_a(input string tag);
        check({tag, "_ser"}, a_ser, 1'b1);
        check({tag, "_ready"}, a_ready, 1'b1);
        check({tag, "_busy"}, a_busy, 1'b0);
        check({tag, "_done"}, a_done, 1'b0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the o_done cycle.
    task automatic run_a(input logic [WA-1:0] d, input bit hold_valid);
        check("a_ready_pre", a_ready, 1'b1);
        a_valid = 1'b1;
        a_data  = d;
        @(negedge clk);
        for (int k = 0; k < LA; k++) begin
            check($sformatf("a_ser[%0h]c%0d", d, k), a_ser, exp_ser(int'(d), WA, DA, k));
            check($sformatf("a_busy[%0h]c%0d", d, k), a_busy, 1'b1);
            check($sformatf("a_ready[%0h]c%0d", d, k), a_ready, 1'b0);
            check($sformatf("a_done[%0h]c%0d", d, k), a_done, 1'b0);
            a_valid = hold_valid;
            a_data  = WA'($urandom);
            @(negedge clk);
        end
        check("a_done_pulse", a_done, 1'b1);
        check("a_ser_gap", a_ser, 1'b1);
        check("a_busy_end", a_busy, 1'b0);
        check("a_ready_end", a_ready, 1'b1);
        a_valid = 1'b0;
    endtask

    task automatic run_b(input logic [WB-1:0] d);
        check("b_ready_pre", b_ready, 1'b1);
        b_valid = 1'b1;
        b_data  = d;
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 0; k < LB; k++) begin
            check($sformatf("b_ser[%0h]c%0d", d, k), b_ser, exp_ser(int'(d), WB, DB, k));
            check($sformatf("b_busy c%0d", k), b_busy, 1'b1);
            check($sformatf("b_done c%0d", k), b_done, 1'b0);
            @(negedge clk);
        end
        check("b_done_pulse", b_done, 1'b1);
        check("b_ser_end", b_ser, 1'b1);
        @(negedge clk);
        check("b_done_single", b_done, 1'b0);
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        idle_a("rst_a");
        check("rst_b_ser", b_ser, 1'b1);
        check("rst_b_ready", b_ready, 1'b1);
        rst_n = 1'b1;

        // Idle for 10 cycles with no valid: line high, no o_done.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_a($sformatf("idle%0d", i));
            check($sformatf("idle_b_done%0d", i), b_done, 1'b0);
        end

        // Directed frames, including the parity-0 and parity-1 words.
        run_a(4'b1010, 1'b0);
        @(negedge clk);
        idle_a("post1010");
        run_a(4'b0111, 1'b0);
        @(negedge clk);
        idle_a("post0111");

        // valid held high with data changing during the frame, second word in the o_done cycle.
        run_a(4'hF, 1'b1);
        run_a(4'h3, 1'b0);
        @(negedge clk);
        idle_a("post_b2b");

        // Random words, some with valid left asserted during the frame.
        repeat (4) begin
            run_a(WA'($urandom), 1'($urandom_range(0, 1)));
            @(negedge clk);
            idle_a("post_rand");
        end

        // DIV=1, WIDTH=1 instance.
        run_b(1'b1);
        run_b(1'b0);
        run_b(1'b1);

        // Asynchronous reset in the middle of DATA (cycle 5 of 0x5 carries data bit 1 = 0).
        a_valid = 1'b1;
        a_data  = 4'h5;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_ser_pre", a_ser, 1'b0);
        check("mid_busy_pre", a_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        idle_a("abort");
        @(negedge clk);
        idle_a("abort_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_a($sformatf("after_abort%0d", i));
        end
        run_a(4'h5, 1'b0);
        @(negedge clk);
        idle_a("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
